// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone configuration master: bus widths,
// FSM encoding and the PWM/timer slave register map.
package wb_pkg;

  localparam int unsigned WB_ADR_W = 16;
  localparam int unsigned WB_DAT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } wb_state_e;

  // PWM/timer slave register offsets
  localparam logic [WB_ADR_W-1:0] REG_CTRL    = 16'h0000;
  localparam logic [WB_ADR_W-1:0] REG_DIVISOR = 16'h0002;
  localparam logic [WB_ADR_W-1:0] REG_PERIOD  = 16'h0004;
  localparam logic [WB_ADR_W-1:0] REG_DUTY    = 16'h0006;

  // Last timeout-counter value before the cycle is abandoned.
  function automatic logic [15:0] tmo_last(input int unsigned timeout);
    return 16'(timeout - 1);
  endfunction

endpackage

// File: rtl/wb_cmd_fifo.sv
// Synchronous command FIFO. Pointers carry one extra wrap bit so that
// full (MSBs differ, rest equal) and empty (pointers equal) are distinct.
module wb_cmd_fifo #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/wb_cfg_master.sv
// Wishbone classic single-transfer master: buffers register commands, runs
// one bus cycle at a time with an ack timeout, returns one response each.
module wb_cfg_master
  import wb_pkg::*;
#(
  parameter int unsigned ADR_W      = WB_ADR_W,
  parameter int unsigned DAT_W      = WB_DAT_W,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic             i_cmd_we,
  input  logic [ADR_W-1:0] i_cmd_adr,
  input  logic [DAT_W-1:0] i_cmd_data,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [DAT_W-1:0] o_rsp_data,
  output logic             o_rsp_err,
  output logic             o_wb_cyc,
  output logic             o_wb_stb,
  output logic             o_wb_we,
  output logic [ADR_W-1:0] o_wb_adr,
  output logic [DAT_W-1:0] o_wb_data,
  input  logic             i_wb_ack,
  input  logic [DAT_W-1:0] i_wb_data,
  output logic             o_busy
);

  localparam int unsigned FW = 1 + ADR_W + DAT_W;
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] TMO_LAST = tmo_last(TIMEOUT);

  logic [FW-1:0]    fifo_rdata;
  logic             fifo_full, fifo_empty;
  logic [CW-1:0]    fifo_count, next_count;
  logic             push, pop, fsm_active_d;
  logic             head_we;
  logic [ADR_W-1:0] head_adr;
  logic [DAT_W-1:0] head_dat;

  wb_state_e        state_q;
  logic             pend_q;
  logic [15:0]      tmo_q;
  logic             cyc_q, stb_q, we_q;
  logic [ADR_W-1:0] adr_q;
  logic [DAT_W-1:0] dat_q;
  logic             rsp_valid_q, rsp_err_q;
  logic [DAT_W-1:0] rsp_data_q;
  logic             busy_q;

  wb_cmd_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (i_clk),
    .rst_ni  (i_rst_n),
    .push_i  (push),
    .wdata_i ({i_cmd_we, i_cmd_adr, i_cmd_data}),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign {head_we, head_adr, head_dat} = fifo_rdata;

  assign o_cmd_ready = !fifo_full;
  assign push        = i_cmd_valid && !fifo_full;
  // pend_q is a one-clock registered view of FIFO occupancy, so a freshly
  // pushed command is launched two edges after acceptance.
  assign pop         = (state_q == ST_IDLE) && pend_q && !fifo_empty;
  assign next_count  = fifo_count + CW'(push) - CW'(pop);

  assign fsm_active_d = (state_q == ST_BUS) ||
                        (state_q == ST_IDLE && pop) ||
                        (state_q == ST_RESP && !i_rsp_ready);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      pend_q      <= 1'b0;
      tmo_q       <= '0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      pend_q <= !fifo_empty;
      busy_q <= (next_count != '0) || fsm_active_d;
      case (state_q)
        ST_IDLE: begin
          if (pop) begin
            we_q    <= head_we;
            adr_q   <= head_adr;
            dat_q   <= head_dat;
            cyc_q   <= 1'b1;
            stb_q   <= 1'b1;
            tmo_q   <= '0;
            state_q <= ST_BUS;
          end
        end
        ST_BUS: begin
          if (i_wb_ack) begin
            rsp_data_q  <= we_q ? '0 : i_wb_data;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            state_q     <= ST_RESP;
          end else if (tmo_q == TMO_LAST) begin
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            state_q     <= ST_RESP;
          end else begin
            tmo_q <= tmo_q + 16'd1;
          end
        end
        ST_RESP: begin
          if (i_rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_wb_cyc    = cyc_q;
  assign o_wb_stb    = stb_q;
  assign o_wb_we     = we_q;
  assign o_wb_adr    = adr_q;
  assign o_wb_data   = dat_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_rsp_err   = rsp_err_q;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_wb_cfg_master.sv
// Directed bench for wb_cfg_master with a small Wishbone slave model.
module tb_wb_cfg_master;
  import wb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_we = 1'b0;
  logic [15:0] cmd_adr = '0, cmd_data = '0;
  logic        cmd_ready, rsp_valid, rsp_err, rsp_ready = 1'b0;
  logic [15:0] rsp_data;
  logic        wb_cyc, wb_stb, wb_we;
  logic [15:0] wb_adr, wb_wdat, wb_rdat;
  logic        wb_ack = 1'b0;
  logic        busy;

  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  wb_cfg_master #(
    .ADR_W      (16),
    .DAT_W      (16),
    .FIFO_DEPTH (4),
    .TIMEOUT    (8)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_cmd_valid (cmd_valid),
    .o_cmd_ready (cmd_ready),
    .i_cmd_we    (cmd_we),
    .i_cmd_adr   (cmd_adr),
    .i_cmd_data  (cmd_data),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_data  (rsp_data),
    .o_rsp_err   (rsp_err),
    .o_wb_cyc    (wb_cyc),
    .o_wb_stb    (wb_stb),
    .o_wb_we     (wb_we),
    .o_wb_adr    (wb_adr),
    .o_wb_data   (wb_wdat),
    .i_wb_ack    (wb_ack),
    .i_wb_data   (wb_rdat),
    .o_busy      (busy)
  );

  // Slave: mode 0 acks one clock after stb, 1 never acks, 2 holds ack high.
  int          ack_mode = 0;
  logic [15:0] slv_mem [8];
  assign wb_rdat = slv_mem[wb_adr[3:1]];

  always @(posedge clk) begin
    case (ack_mode)
      0:       wb_ack <= wb_cyc & wb_stb & ~wb_ack;
      2:       wb_ack <= 1'b1;
      default: wb_ack <= 1'b0;
    endcase
  end

  // Bus monitor: transfer count, length, signal stability, min cyc-low gap.
  int          mon_xfers = 0, mon_len = 0, mon_gap = 0, mon_min_gap = 1000, mon_unstable = 0;
  logic        mon_prev = 1'b0, mon_we = 1'b0;
  logic [15:0] mon_adr = '0, mon_dat = '0;

  always @(negedge clk) begin
    if (wb_cyc === 1'b1) begin
      if (!mon_prev) begin
        mon_xfers++;
        mon_len = 0;
        if (mon_xfers > 1 && mon_gap < mon_min_gap) mon_min_gap = mon_gap;
        mon_we = wb_we; mon_adr = wb_adr; mon_dat = wb_wdat;
      end else if (wb_we !== mon_we || wb_adr !== mon_adr || wb_wdat !== mon_dat) begin
        mon_unstable++;
      end
      if (wb_stb !== 1'b1) mon_unstable++;
      mon_len++;
      mon_prev = 1'b1;
    end else begin
      if (wb_stb === 1'b1) mon_unstable++;
      mon_gap  = mon_prev ? 1 : mon_gap + 1;
      mon_prev = 1'b0;
    end
  end

  task automatic mon_clear();
    mon_xfers = 0; mon_min_gap = 1000; mon_unstable = 0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_cmd(input logic we, input logic [15:0] adr, input logic [15:0] dat);
    int g = 0;
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_data = dat;
    while (!cmd_ready && g < 200) begin @(negedge clk); g++; end
    check("cmd_ready_wait", {31'b0, cmd_ready}, 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(output logic [15:0] d, output logic e);
    int g = 0;
    while (!rsp_valid && g < 100) begin @(negedge clk); g++; end
    check("rsp_wait", {31'b0, rsp_valid}, 32'd1);
    d = rsp_data; e = rsp_err;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  logic [15:0] col_d [8];
  logic        col_e [8];

  // Requires rsp_ready held high, so each high sample is a distinct response.
  task automatic collect(input int n, output int got);
    int g = 0;
    got = 0;
    while (got < n && g < 400) begin
      if (rsp_valid) begin col_d[got] = rsp_data; col_e[got] = rsp_err; got++; end
      @(negedge clk); g++;
    end
  endtask

  typedef struct packed {
    logic        we;
    logic [15:0] adr;
    logic [15:0] wdat;
    logic [7:0]  mode;
    logic [15:0] exp_data;
    logic        exp_err;
    logic [7:0]  exp_len;
  } vec_t;

  vec_t vecs [8];
  logic [15:0] fill_adr [6];
  logic [15:0] fill_exp [7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] d;
    logic        e;
    int          acc, got, seen;
    logic        rdy_now;

    slv_mem[0] = 16'h00C1; slv_mem[1] = 16'h0A0B; slv_mem[2] = 16'h1234;
    slv_mem[3] = 16'h0032; slv_mem[4] = 16'hFFFF; slv_mem[5] = 16'h0000;
    slv_mem[6] = 16'h0000; slv_mem[7] = 16'h0000;

    //         we    adr          wdat      mode  exp_data  err   len
    vecs[0] = '{1'b1, REG_DIVISOR, 16'h0004, 8'd0, 16'h0000, 1'b0, 8'd2};
    vecs[1] = '{1'b0, REG_DUTY,    16'h0000, 8'd0, 16'h0032, 1'b0, 8'd2};
    vecs[2] = '{1'b1, 16'h0008,    16'h55AA, 8'd1, 16'h0000, 1'b1, 8'd8};
    vecs[3] = '{1'b0, REG_CTRL,    16'h0000, 8'd0, 16'h00C1, 1'b0, 8'd2};
    vecs[4] = '{1'b0, REG_PERIOD,  16'h0000, 8'd1, 16'h0000, 1'b1, 8'd8};
    vecs[5] = '{1'b0, REG_PERIOD,  16'h0000, 8'd2, 16'h1234, 1'b0, 8'd1};
    vecs[6] = '{1'b1, REG_DUTY,    16'h0100, 8'd2, 16'h0000, 1'b0, 8'd1};
    vecs[7] = '{1'b0, REG_DIVISOR, 16'h0000, 8'd0, 16'h0A0B, 1'b0, 8'd2};

    fill_adr[0] = 16'h0000; fill_adr[1] = 16'h0002; fill_adr[2] = 16'h0004;
    fill_adr[3] = 16'h0006; fill_adr[4] = 16'h0008; fill_adr[5] = 16'h0000;
    fill_exp[0] = 16'h0032; fill_exp[1] = 16'h00C1; fill_exp[2] = 16'h0A0B;
    fill_exp[3] = 16'h1234; fill_exp[4] = 16'h0032; fill_exp[5] = 16'hFFFF;
    fill_exp[6] = 16'h00C1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cyc", {31'b0, wb_cyc}, 0);
    check("rst_stb", {31'b0, wb_stb}, 0);
    check("rst_we", {31'b0, wb_we}, 0);
    check("rst_adr", {16'b0, wb_adr}, 0);
    check("rst_wdat", {16'b0, wb_wdat}, 0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 0);
    check("rst_rsp_data", {16'b0, rsp_data}, 0);
    check("rst_rsp_err", {31'b0, rsp_err}, 0);
    check("rst_cmd_ready", {31'b0, cmd_ready}, 1);
    check("rst_busy", {31'b0, busy}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven single transfers
    for (int i = 0; i < 8; i++) begin
      ack_mode = int'(vecs[i].mode);
      mon_clear();
      @(negedge clk);
      send_cmd(vecs[i].we, vecs[i].adr, vecs[i].wdat);
      get_rsp(d, e);
      check($sformatf("v%0d_rsp_data", i), {16'b0, d}, {16'b0, vecs[i].exp_data});
      check($sformatf("v%0d_rsp_err", i), {31'b0, e}, {31'b0, vecs[i].exp_err});
      check($sformatf("v%0d_cyc_len", i), mon_len, {24'b0, vecs[i].exp_len});
      check($sformatf("v%0d_xfers", i), mon_xfers, 1);
      check($sformatf("v%0d_wb_we", i), {31'b0, mon_we}, {31'b0, vecs[i].we});
      check($sformatf("v%0d_wb_adr", i), {16'b0, mon_adr}, {16'b0, vecs[i].adr});
      check($sformatf("v%0d_wb_dat", i), {16'b0, mon_dat}, {16'b0, vecs[i].wdat});
      check($sformatf("v%0d_stable", i), mon_unstable, 0);
      @(negedge clk);
    end

    // Launch latency into an idle block
    ack_mode = 0;
    repeat (2) @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = REG_CTRL; cmd_data = '0;
    check("lat_ready", {31'b0, cmd_ready}, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("lat_cyc_n0", {31'b0, wb_cyc}, 0);
    check("lat_busy", {31'b0, busy}, 1);
    @(negedge clk);
    check("lat_cyc_n1", {31'b0, wb_cyc}, 0);
    @(negedge clk);
    check("lat_cyc_n2", {31'b0, wb_cyc}, 1);
    get_rsp(d, e);
    check("lat_rsp_data", {16'b0, d}, 32'h00C1);

    // FIFO fill under response backpressure
    ack_mode = 0; rsp_ready = 1'b0;
    @(negedge clk);
    send_cmd(1'b0, REG_DUTY, 16'h0000);
    for (int g = 0; g < 50 && !rsp_valid; g++) @(negedge clk);
    check("fill_stalled_rsp", {31'b0, rsp_valid}, 1);
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      if (acc < 6) begin cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = fill_adr[acc]; cmd_data = '0; end
      rdy_now = cmd_ready;
      @(negedge clk);
      if (rdy_now && cmd_valid) acc++;
    end
    cmd_valid = 1'b0;
    check("fill_accepted", acc, 4);
    check("fill_ready_low", {31'b0, cmd_ready}, 0);
    check("fill_busy", {31'b0, busy}, 1);
    check("fill_rsp_held", {31'b0, rsp_valid}, 1);
    rsp_ready = 1'b1;
    fork
      begin send_cmd(1'b0, fill_adr[4], 16'h0000); send_cmd(1'b0, fill_adr[5], 16'h0000); end
      collect(7, got);
    join
    check("fill_rsp_count", got, 7);
    for (int i = 0; i < 7; i++) begin
      check($sformatf("fill_rsp%0d_data", i), {16'b0, col_d[i]}, {16'b0, fill_exp[i]});
      check($sformatf("fill_rsp%0d_err", i), {31'b0, col_e[i]}, 0);
    end
    check("fill_busy_after", {31'b0, busy}, 0);
    check("fill_ready_after", {31'b0, cmd_ready}, 1);
    rsp_ready = 1'b0;

    // Reset in the middle of a bus cycle, with a second command queued
    ack_mode = 1;
    @(negedge clk);
    send_cmd(1'b1, REG_PERIOD, 16'h0777);
    send_cmd(1'b1, REG_DUTY, 16'h0333);
    for (int g = 0; g < 20 && !wb_cyc; g++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("mrst_pre_cyc", {31'b0, wb_cyc}, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("mrst_cyc", {31'b0, wb_cyc}, 0);
    check("mrst_stb", {31'b0, wb_stb}, 0);
    check("mrst_rsp_valid", {31'b0, rsp_valid}, 0);
    check("mrst_cmd_ready", {31'b0, cmd_ready}, 1);
    check("mrst_busy", {31'b0, busy}, 0);
    rst_n = 1'b1;
    ack_mode = 0;
    mon_clear();
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (rsp_valid || wb_cyc || busy) seen++;
    end
    check("mrst_quiet", seen, 0);
    check("mrst_xfers", mon_xfers, 0);

    // Ack held high across back-to-back transactions
    ack_mode = 2; rsp_ready = 1'b1;
    mon_clear();
    fork
      begin
        send_cmd(1'b0, REG_CTRL, 16'h0000);
        send_cmd(1'b0, REG_DIVISOR, 16'h0000);
        send_cmd(1'b0, REG_PERIOD, 16'h0000);
      end
      collect(3, got);
    join
    check("ackhi_rsp_count", got, 3);
    check("ackhi_d0", {16'b0, col_d[0]}, 32'h00C1);
    check("ackhi_d1", {16'b0, col_d[1]}, 32'h0A0B);
    check("ackhi_d2", {16'b0, col_d[2]}, 32'h1234);
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("ackhi_no_extra_rsp", seen, 0);
    check("ackhi_xfers", mon_xfers, 3);
    check("ackhi_gap_ge2", {31'b0, (mon_min_gap >= 2)}, 1);
    check("ackhi_stable", mon_unstable, 0);
    rsp_ready = 1'b0;
    ack_mode = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_cfg_master.md
# wb_cfg_master

Wishbone classic single-transfer master that turns a stream of register commands into bus cycles toward the PWM/timer register slave. Sits between a local command source (sequencer, UART bridge or test controller) and the slave's Wishbone port. Commands are buffered in a small FIFO, one bus cycle runs at a time with an ack timeout, and each command produces exactly one response.

## Interface
Parameters:
- ADR_W, 16, Wishbone address width
- DAT_W, 16, Wishbone data width
- FIFO_DEPTH, 4, command FIFO entries (power of two, ≥2)
- TIMEOUT, 255, maximum clocks to wait for ack (1..65535)

Ports:
- i_clk  in  1  system clock, rising edge
- i_rst_n  in  1  reset, synchronous, active-low
- i_cmd_valid  in  1  command offered
- o_cmd_ready  out  1  FIFO not full
- i_cmd_we  in  1  1 write, 0 read
- i_cmd_adr  in  ADR_W  target address
- i_cmd_data  in  DAT_W  write data (ignored for reads)
- o_rsp_valid  out  1  response available
- i_rsp_ready  in  1  response consumed
- o_rsp_data  out  DAT_W  read data (0 for writes and errors)
- o_rsp_err  out  1  1 = ack timeout
- o_wb_cyc, o_wb_stb  out  1  bus cycle / strobe
- o_wb_we  out  1  write enable
- o_wb_adr  out  ADR_W  address
- o_wb_data  out  DAT_W  write data
- i_wb_ack  in  1  slave acknowledge
- i_wb_data  in  DAT_W  slave read data
- o_busy  out  1  FIFO non-empty or FSM not IDLE

## Operation
- Command accepted on an edge with i_cmd_valid & o_cmd_ready and pushed into the FIFO.
- FSM states: IDLE, BUS, RESP.
- IDLE: if the FIFO is non-empty, pop the head, load o_wb_we/adr/data, assert cyc and stb, clear the timeout counter, and go to BUS.
- BUS: cyc and stb stay high and adr/we/data stay stable.
  - i_wb_ack=1: capture i_wb_data (reads only, else 0), set err=0, drop cyc/stb, go to RESP.
  - Otherwise the counter increments. When the counter reaches TIMEOUT-1 without ack: set err=1 and data=0, drop cyc/stb, go to RESP.
- RESP: o_rsp_valid=1 and data/err held stable. On an edge with i_rsp_ready=1, go to IDLE.
- One response per command, in command order. Writes also produce a response.
- Push and pop on the same edge are both allowed. With the FIFO full, o_cmd_ready=0, and a push is accepted only after a pop frees an entry (no bypass).
- FIFO pointers are log2(FIFO_DEPTH)+1 bits and wrap modulo 2·FIFO_DEPTH. Full when the MSBs differ and the rest match. Empty when the pointers are equal.
- An ack arriving in IDLE or RESP is ignored.

## Timing
- All outputs are registered.
- Reset (i_rst_n=0 at an edge):
  - cyc, stb, we = 0; adr, data = 0
  - o_rsp_valid=0, o_rsp_data=0, o_rsp_err=0
  - FIFO flushed; o_cmd_ready=1; FSM=IDLE
  - Applies mid-cycle: cyc/stb fall at that edge and the in-flight command is dropped with no response.
- Latency, command into an idle block: accepted at edge N, FIFO visible at N+1, cyc/stb high after edge N+2.
- Ack sampled at edge M: cyc/stb low and o_rsp_valid high after M.
- Minimum of one RESP cycle plus one IDLE cycle between bus cycles, so cyc is always low for ≥2 clocks between transfers.
- Timeout: with no ack, cyc/stb are high for exactly TIMEOUT clocks.
- Response backpressure stalls the FSM. The FIFO keeps accepting commands until full.

## Structure
- Shared package `wb_pkg`: ADR_W/DAT_W defaults, FSM state encoding (IDLE=2'd0, BUS=2'd1, RESP=2'd2), and register offsets CTRL=0, DIVISOR=2, PERIOD=4, DUTY=6.
- Sub-module `wb_cmd_fifo`: synchronous FIFO of width 1+ADR_W+DAT_W with push/pop/full/empty, active-low synchronous reset.
- Top level holds the FSM, timeout counter and response register.

## Test plan
- Write adr 0x0002 data 0x0004, slave acks 1 clock after stb -> one bus cycle with we=1, adr=0x0002, data=0x0004; response err=0, data=0x0000.
- Read adr 0x0006, slave returns 0x0032 with ack -> o_rsp_data=0x0032, err=0; cyc high for exactly 2 clocks.
- Write to adr 0x0008 with the slave never acking, TIMEOUT=8 -> cyc/stb high for 8 clocks, response err=1, data=0; next command then proceeds normally.
- Push 6 commands back-to-back with FIFO_DEPTH=4 and i_rsp_ready=0 -> o_cmd_ready falls after 4 pushes; the FIFO keeps 4 entries and the 5th command is stalled on the interface until the first pop. Then raise i_rsp_ready=1 -> responses come out in order and o_busy falls after the last one.
- Assert i_rst_n=0 for 1 clock in the middle of a BUS cycle -> cyc/stb low at that edge, no response, o_cmd_ready=1, FIFO empty.
- Ack held high continuously across transactions -> each command still gives exactly one response, and cyc drops for ≥2 clocks between transfers.
